// File: rtl/matmul_mem_sequencer.sv
// matmul_mem_sequencer
// Host-side sequencer for a tiled systolic matmul core. In IDLE the host
// loads the A/B operand banks. A start pulse hands the bank addresses to
// the core for the RUN phase. After the core finishes, the C banks are
// streamed out bank by bank through a two-entry output buffer with a
// valid/ready handshake.
module matmul_mem_sequencer #(
  parameter int DWIDTH    = 16,
  parameter int BB_SIZE   = 32,
  parameter int AWIDTH    = 7,
  parameter int NUM_TILES = 2,
  parameter int C_DEPTH   = 32,
  localparam int W        = BB_SIZE * DWIDTH,
  localparam int BW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic                          host_wr_sel,
  input  logic [BW-1:0]                 host_wr_bank,
  input  logic [AWIDTH-1:0]             host_wr_addr,
  input  logic [W-1:0]                  host_wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   run_cycles,
  output logic                          core_start,
  input  logic                          core_done,
  input  logic [NUM_TILES*AWIDTH-1:0]   core_a_addr,
  input  logic [NUM_TILES*AWIDTH-1:0]   core_b_addr,
  output logic [NUM_TILES*AWIDTH-1:0]   mem_a_addr,
  output logic [NUM_TILES-1:0]          mem_a_we,
  output logic [NUM_TILES*AWIDTH-1:0]   mem_b_addr,
  output logic [NUM_TILES-1:0]          mem_b_we,
  output logic [W-1:0]                  mem_wdata,
  output logic [NUM_TILES*AWIDTH-1:0]   c_mem_addr,
  input  logic [NUM_TILES*W-1:0]        c_mem_rdata,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [W-1:0]                  rd_data,
  output logic                          rd_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(C_DEPTH - 1);
  localparam logic [BW-1:0]     BANK_LAST = BW'(NUM_TILES - 1);

  // Saturating increment for the run-cycle counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]                  state_q, state_d;
  logic [15:0]                 run_q;

  logic [NUM_TILES-1:0]        a_we_q, b_we_q;
  logic [NUM_TILES*AWIDTH-1:0] a_addr_q, b_addr_q;
  logic [W-1:0]                wdata_q;

  logic [BW-1:0]               req_bank_q;
  logic [AWIDTH-1:0]           req_addr_q;
  logic                        req_done_q;
  logic                        rsp_vld_q;
  logic [BW-1:0]               rsp_bank_q;
  logic                        rsp_last_q;

  logic [W-1:0]                buf_data_q [2];
  logic                        buf_last_q [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  cnt_q;

  logic                        bank_ok, wr_fire;
  logic                        pop, push, issue, req_is_last;
  logic [2:0]                  occ;
  logic [W-1:0]                rsp_word;
  logic [NUM_TILES*AWIDTH-1:0] c_addr;

  // Writes are only taken in IDLE; an out-of-range bank is accepted but dropped.
  assign host_wr_ready = (state_q == S_IDLE);
  assign bank_ok       = (int'(host_wr_bank) < NUM_TILES);
  assign wr_fire       = host_wr_valid && host_wr_ready && bank_ok;

  assign busy       = (state_q == S_RUN) || (state_q == S_READ);
  assign done       = (state_q == S_DONE);
  assign core_start = (state_q == S_RUN);
  assign run_cycles = run_q;

  assign mem_a_we   = a_we_q;
  assign mem_b_we   = b_we_q;
  assign mem_a_addr = a_addr_q;
  assign mem_b_addr = b_addr_q;
  assign mem_wdata  = wdata_q;

  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = rd_valid ? buf_data_q[rd_ptr_q] : '0;
  assign rd_last  = rd_valid && buf_last_q[rd_ptr_q];
  assign pop      = rd_valid && rd_ready;
  assign push     = rsp_vld_q;

  // A new C read is issued only if the buffer can still hold it once the
  // word already in flight has landed, counting a pop happening this cycle.
  assign occ         = {1'b0, cnt_q} + {2'b00, rsp_vld_q} - {2'b00, pop};
  assign req_is_last = (req_bank_q == BANK_LAST) && (req_addr_q == ADDR_LAST);
  assign issue       = (state_q == S_READ) && !req_done_q && (occ < 3'd2);

  // Next-state logic for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (core_done) state_d = S_READ;
      S_READ:  if (pop && rd_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Run-cycle counter: cleared on RUN entry, counts every RUN cycle, then holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          run_q <= '0;
    else if ((state_q == S_IDLE) && start) run_q <= '0;
    else if (state_q == S_RUN)             run_q <= sat_inc16(run_q);
  end

  // A/B bank port: host writes in IDLE, registered core addresses otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_we_q   <= '0;
      b_we_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      wdata_q  <= '0;
    end else begin
      a_we_q <= '0;
      b_we_q <= '0;
      if (state_q == S_IDLE) begin
        if (wr_fire) begin
          wdata_q <= host_wr_data;
          for (int i = 0; i < NUM_TILES; i++) begin
            if (BW'(i) == host_wr_bank) begin
              if (host_wr_sel) begin
                b_we_q[i]                    <= 1'b1;
                b_addr_q[i*AWIDTH +: AWIDTH] <= host_wr_addr;
              end else begin
                a_we_q[i]                    <= 1'b1;
                a_addr_q[i*AWIDTH +: AWIDTH] <= host_wr_addr;
              end
            end
          end
        end
      end else begin
        a_addr_q <= core_a_addr;
        b_addr_q <= core_b_addr;
      end
    end
  end

  // C read address walker: bank-major, address-minor; rearmed during RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_bank_q <= '0;
      req_addr_q <= '0;
      req_done_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      req_bank_q <= '0;
      req_addr_q <= '0;
      req_done_q <= 1'b0;
    end else if (issue) begin
      if (req_is_last) begin
        req_done_q <= 1'b1;
      end else if (req_addr_q == ADDR_LAST) begin
        req_addr_q <= '0;
        req_bank_q <= req_bank_q + BW'(1);
      end else begin
        req_addr_q <= req_addr_q + AWIDTH'(1);
      end
    end
  end

  // Only the bank currently being walked sees a non-zero read address.
  always_comb begin
    c_addr = '0;
    if (state_q == S_READ) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (BW'(i) == req_bank_q) c_addr[i*AWIDTH +: AWIDTH] = req_addr_q;
      end
    end
  end
  assign c_mem_addr = c_addr;

  // Tracks the read whose data appears on c_mem_rdata one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_bank_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      rsp_vld_q  <= issue;
      rsp_bank_q <= req_bank_q;
      rsp_last_q <= req_is_last;
    end
  end

  // Pick the returning word from the bank it was read from.
  always_comb begin
    rsp_word = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (BW'(i) == rsp_bank_q) rsp_word = c_mem_rdata[i*W +: W];
    end
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Output buffer storage; contents are masked by rd_valid so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= rsp_word;
      buf_last_q[wr_ptr_q] <= rsp_last_q;
    end
  end

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Bench for matmul_mem_sequencer: directed host writes, runs and C readouts
// with a behavioural model checked every cycle, plus literal expectations.
module tb_matmul_mem_sequencer;

  localparam int DW = 8;
  localparam int BB = 4;
  localparam int AW = 7;
  localparam int NT = 2;
  localparam int CD = 32;
  localparam int W  = DW * BB;
  localparam int BW = 1;
  localparam int NWORDS = NT * CD;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_READ = 2;
  localparam int M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic              host_wr_sel;
  logic [BW-1:0]     host_wr_bank;
  logic [AW-1:0]     host_wr_addr;
  logic [W-1:0]      host_wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       run_cycles;
  logic              core_start;
  logic              core_done;
  logic [NT*AW-1:0]  core_a_addr;
  logic [NT*AW-1:0]  core_b_addr;
  logic [NT*AW-1:0]  mem_a_addr;
  logic [NT-1:0]     mem_a_we;
  logic [NT*AW-1:0]  mem_b_addr;
  logic [NT-1:0]     mem_b_we;
  logic [W-1:0]      mem_wdata;
  logic [NT*AW-1:0]  c_mem_addr;
  logic [NT*W-1:0]   c_mem_rdata;
  logic              rd_valid;
  logic              rd_ready;
  logic [W-1:0]      rd_data;
  logic              rd_last;

  matmul_mem_sequencer #(
    .DWIDTH(DW), .BB_SIZE(BB), .AWIDTH(AW), .NUM_TILES(NT), .C_DEPTH(CD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_sel(host_wr_sel), .host_wr_bank(host_wr_bank),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .start(start), .busy(busy), .done(done), .run_cycles(run_cycles),
    .core_start(core_start), .core_done(core_done),
    .core_a_addr(core_a_addr), .core_b_addr(core_b_addr),
    .mem_a_addr(mem_a_addr), .mem_a_we(mem_a_we),
    .mem_b_addr(mem_b_addr), .mem_b_we(mem_b_we),
    .mem_wdata(mem_wdata), .c_mem_addr(c_mem_addr), .c_mem_rdata(c_mem_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Contents of C bank b at address a.
  function automatic logic [W-1:0] cword(input int b, input int a);
    logic [15:0] mix;
    mix = 16'hBEEF ^ 16'(a * 37 + b);
    return {8'(b + 1), 8'(a), mix};
  endfunction

  // C banks: synchronous read, one cycle latency.
  always @(posedge clk) begin
    for (int b = 0; b < NT; b++)
      c_mem_rdata[b*W +: W] <= cword(b, int'(c_mem_addr[b*AW +: AW]));
  end

  // rd_ready: held high or driven from an LFSR.
  bit          rd_mode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = rd_mode ? lfsr[0] : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Behavioural model state.
  int          m_st = M_IDLE;
  int          m_run = 0;
  int          m_idx = 0;
  int          cyc = 0;
  int          first_hs = 0;
  int          last_hs = 0;
  logic [W-1:0]  m_wdata = '0;
  logic [NT-1:0] exp_a_we = '0;
  logic [NT-1:0] exp_b_we = '0;
  logic [AW-1:0] exp_addr = '0;
  int          exp_bank = 0;
  bit          prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;
  logic          prev_last = 1'b0;

  // Per-cycle compare against the model, then advance the model using the
  // inputs that the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_st = M_IDLE; m_run = 0; m_idx = 0; m_wdata = '0;
      exp_a_we = '0; exp_b_we = '0; prev_stall = 1'b0;
    end else begin
      chk("ready",      64'(host_wr_ready), 64'(m_st == M_IDLE));
      chk("busy",       64'(busy),          64'(m_st == M_RUN || m_st == M_READ));
      chk("core_start", 64'(core_start),    64'(m_st == M_RUN));
      chk("done",       64'(done),          64'(m_st == M_DONE));
      chk("run_cycles", 64'(run_cycles),    64'(m_run));
      chk("a_we",       64'(mem_a_we),      64'(exp_a_we));
      chk("b_we",       64'(mem_b_we),      64'(exp_b_we));
      chk("wdata",      64'(mem_wdata),     64'(m_wdata));
      if (exp_a_we != '0) chk("a_addr_wr", 64'(mem_a_addr[exp_bank*AW +: AW]), 64'(exp_addr));
      if (exp_b_we != '0) chk("b_addr_wr", 64'(mem_b_addr[exp_bank*AW +: AW]), 64'(exp_addr));
      if (m_st != M_READ) chk("rd_valid_quiet", 64'(rd_valid), 64'(0));
      if (prev_stall) begin
        chk("stall_valid", 64'(rd_valid), 64'(1));
        chk("stall_data",  64'(rd_data),  64'(prev_data));
        chk("stall_last",  64'(rd_last),  64'(prev_last));
      end

      exp_a_we = '0;
      exp_b_we = '0;
      if (host_wr_valid && m_st == M_IDLE && int'(host_wr_bank) < NT) begin
        if (host_wr_sel) exp_b_we[host_wr_bank] = 1'b1;
        else             exp_a_we[host_wr_bank] = 1'b1;
        exp_bank = int'(host_wr_bank);
        exp_addr = host_wr_addr;
        m_wdata  = host_wr_data;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;

      case (m_st)
        M_IDLE: if (start) begin m_st = M_RUN; m_run = 0; end
        M_RUN: begin
          if (m_run < 65535) m_run++;
          if (core_done) begin m_st = M_READ; m_idx = 0; end
        end
        M_READ: if (rd_valid && rd_ready) begin
          chk("rd_data", 64'(rd_data), 64'(cword(m_idx / CD, m_idx % CD)));
          chk("rd_last", 64'(rd_last), 64'(m_idx == NWORDS - 1));
          if (m_idx == 0) first_hs = cyc;
          last_hs = cyc;
          if (m_idx == NWORDS - 1) m_st = M_DONE;
          m_idx++;
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input int ncyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == ncyc) core_done = 1'b1;
      tick();
    end
    core_done = 1'b0;
  endtask

  // Let a readout finish; optionally poke start/core_done mid-READ.
  task automatic run_read(input string tag, input bit inject);
    int nd;
    nd = 0;
    for (int c = 0; c < 400; c++) begin
      if (done) nd++;
      if (inject && c == 20) begin start = 1'b1; core_done = 1'b1; end
      if (inject && c == 21) begin start = 1'b0; core_done = 1'b0; end
      tick();
    end
    chk({tag, "_done_pulses"}, 64'(nd), 64'(1));
    chk({tag, "_words"},       64'(m_idx), 64'(NWORDS));
    chk({tag, "_idle_busy"},   64'(busy), 64'(0));
    chk({tag, "_idle_ready"},  64'(host_wr_ready), 64'(1));
  endtask

  initial begin
    int cs_count;
    reset_n = 1'b0;
    host_wr_valid = 1'b0; host_wr_sel = 1'b0; host_wr_bank = '0;
    host_wr_addr = '0; host_wr_data = '0;
    start = 1'b0; core_done = 1'b0;
    core_a_addr = '0; core_b_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_core_start", 64'(core_start), 64'(0));
    chk("rst_rd_valid",   64'(rd_valid),   64'(0));
    chk("rst_run_cycles", 64'(run_cycles), 64'(0));
    chk("rst_we",         64'({mem_a_we, mem_b_we}), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 64'(host_wr_ready), 64'(1));

    // Host write to A bank 0.
    host_wr_valid = 1'b1; host_wr_sel = 1'b0; host_wr_bank = 1'b0;
    host_wr_addr = 7'd3; host_wr_data = 32'h1234_5678;
    tick();
    host_wr_valid = 1'b0;
    chk("wrA_we",    64'(mem_a_we), 64'(2'b01));
    chk("wrA_addr",  64'(mem_a_addr[AW-1:0]), 64'(7'd3));
    chk("wrA_wdata", 64'(mem_wdata), 64'(32'h1234_5678));

    // Host write to B bank 1, addr 5.
    host_wr_valid = 1'b1; host_wr_sel = 1'b1; host_wr_bank = 1'b1;
    host_wr_addr = 7'd5; host_wr_data = 32'hDEAD_BEEF;
    tick();
    host_wr_valid = 1'b0;
    chk("wrB_b_we",  64'(mem_b_we), 64'(2'b10));
    chk("wrB_a_we",  64'(mem_a_we), 64'(2'b00));
    chk("wrB_addr",  64'(mem_b_addr[AW +: AW]), 64'(7'd5));
    chk("wrB_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    tick();
    chk("wrB_we_clear", 64'(mem_b_we), 64'(2'b00));

    // core_done in IDLE is ignored.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("idle_core_done_busy", 64'(busy), 64'(0));

    // start together with a write: write lands, then 100-cycle RUN.
    core_a_addr = {7'd11, 7'd22};
    core_b_addr = {7'd33, 7'd44};
    start = 1'b1;
    host_wr_valid = 1'b1; host_wr_sel = 1'b0; host_wr_bank = 1'b1;
    host_wr_addr = 7'd9; host_wr_data = 32'hCAFE_0001;
    tick();
    start = 1'b0;
    host_wr_valid = 1'b0;
    chk("sw_a_we",  64'(mem_a_we), 64'(2'b10));
    chk("sw_addr",  64'(mem_a_addr[AW +: AW]), 64'(7'd9));
    chk("sw_busy",  64'(busy), 64'(1));
    cs_count = 0;
    for (int k = 1; k <= 100; k++) begin
      if (core_start) cs_count++;
      if (k == 50) begin
        host_wr_valid = 1'b1; host_wr_sel = 1'b1; host_wr_bank = 1'b0; start = 1'b1;
      end
      if (k == 51) begin
        host_wr_valid = 1'b0; start = 1'b0;
        chk("run_no_we",      64'({mem_a_we, mem_b_we}), 64'(0));
        chk("run_mem_a_addr", 64'(mem_a_addr), 64'({7'd11, 7'd22}));
        chk("run_mem_b_addr", 64'(mem_b_addr), 64'({7'd33, 7'd44}));
      end
      if (k == 100) core_done = 1'b1;
      tick();
    end
    core_done = 1'b0;
    chk("core_start_cycles", 64'(cs_count), 64'(100));
    chk("run_cycles_100",    64'(run_cycles), 64'(100));
    chk("core_start_drop",   64'(core_start), 64'(0));
    chk("read_busy",         64'(busy), 64'(1));

    // Readout with rd_ready high, stray start/core_done mid-READ.
    run_read("full", 1'b1);
    chk("full_span",      64'(last_hs - first_hs), 64'(NWORDS - 1));
    chk("run_cycles_hold", 64'(run_cycles), 64'(100));

    // Readout with rd_ready toggling.
    rd_mode = 1'b1;
    do_run(10);
    chk("run_cycles_10", 64'(run_cycles), 64'(10));
    run_read("rand", 1'b0);
    rd_mode = 1'b0;

    // Reset when word 10 of READ has been taken.
    do_run(5);
    for (int c = 0; c < 200 && m_idx < 10; c++) tick();
    chk("reach_word10", 64'(m_idx), 64'(10));
    reset_n = 1'b0;
    #1;
    chk("mrst_busy",   64'(busy), 64'(0));
    chk("mrst_done",   64'(done), 64'(0));
    chk("mrst_cs",     64'(core_start), 64'(0));
    chk("mrst_rd",     64'({rd_valid, rd_last}), 64'(0));
    chk("mrst_rddata", 64'(rd_data), 64'(0));
    chk("mrst_run",    64'(run_cycles), 64'(0));
    chk("mrst_we",     64'({mem_a_we, mem_b_we}), 64'(0));
    chk("mrst_addr",   64'({mem_a_addr, mem_b_addr}), 64'(0));
    chk("mrst_caddr",  64'(c_mem_addr), 64'(0));
    chk("mrst_wdata",  64'(mem_wdata), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("mrst_ready", 64'(host_wr_ready), 64'(1));
    do_run(7);
    chk("run_cycles_7", 64'(run_cycles), 64'(7));
    run_read("post_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
